// File: rtl/sb_dsp_pkg.sv
// Shared constants and state types for the Sound Blaster DSP front end.
// Port offsets are relative to the DSP base; opcodes are the DSP command bytes handled here.
package sb_dsp_pkg;

   localparam logic [3:0] OFS_RESET = 4'h6;
   localparam logic [3:0] OFS_READ  = 4'hA;
   localparam logic [3:0] OFS_WRITE = 4'hC;
   localparam logic [3:0] OFS_STAT  = 4'hE;

   localparam logic [7:0] OP_DIRECT  = 8'h10;
   localparam logic [7:0] OP_DMA_SC  = 8'h14;
   localparam logic [7:0] OP_DMA_AI  = 8'h1C;
   localparam logic [7:0] OP_SET_TC  = 8'h40;
   localparam logic [7:0] OP_SET_BLK = 8'h48;
   localparam logic [7:0] OP_PAUSE   = 8'hD0;
   localparam logic [7:0] OP_SPK_ON  = 8'hD1;
   localparam logic [7:0] OP_SPK_OFF = 8'hD3;
   localparam logic [7:0] OP_CONT    = 8'hD4;
   localparam logic [7:0] OP_EXIT_AI = 8'hDA;
   localparam logic [7:0] OP_VERSION = 8'hE1;

   localparam logic [7:0] RESET_ACK = 8'hAA;
   localparam logic [7:0] TC_RESET  = 8'h83;

   typedef enum logic [1:0] {DMA_IDLE, DMA_WAIT, DMA_REQ, DMA_PAUSE} dma_st_e;
   typedef enum logic [1:0] {PS_CMD, PS_ARG1, PS_ARG2} ps_st_e;

endpackage

// File: rtl/sb_dma_pacer.sv
// DMA pacing timer: period = (256-TC) microseconds, counted in clk cycles.
// The counter saturates at the period so rdy_o stays up until the engine restarts it.
module sb_dma_pacer #(
   parameter int CLK_PER_US = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic [7:0] tc_i,
   output logic       rdy_o
);

   localparam int CW = $clog2(256 * CLK_PER_US + 1);

   logic [8:0]    steps;
   logic [CW-1:0] period;
   logic [CW-1:0] cnt_q, cnt_d;

   assign steps  = 9'd256 - {1'b0, tc_i};
   assign period = CW'(steps) * CW'(CLK_PER_US);
   assign rdy_o  = (cnt_q >= period);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)              cnt_d = '0;
      else if (cnt_q < period) cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sb_dsp_dma.sv
// Sound Blaster DSP front end: port decode, command parser, paced 8-bit DMA engine,
// DSP interrupt and PCM byte hand-off to the S/PDIF mixer.
module sb_dsp_dma import sb_dsp_pkg::*; #(
   parameter logic [9:0]  BASE_ADDR  = 10'h220,
   parameter int          CLK_PER_US = 50,
   parameter int          LEN_W      = 17,
   parameter int          IRQ_PULSE  = 9,
   parameter logic [15:0] DSP_VER    = 16'h0201
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] a,
   input  logic       aen,
   input  logic       ior_n,
   input  logic       iow_n,
   input  logic       dack_n,
   input  logic [7:0] d_in,
   output logic [7:0] d_out,
   output logic       d_oe,
   output logic       drq,
   output logic       irq,
   output logic [7:0] pcm,
   output logic       pcm_stb,
   output logic       speaker_on,
   output logic       busy
);

   localparam int ICW = (IRQ_PULSE > 1) ? $clog2(IRQ_PULSE) : 1;
   localparam logic [9:0] A_RST  = BASE_ADDR + 10'(OFS_RESET);
   localparam logic [9:0] A_RD   = BASE_ADDR + 10'(OFS_READ);
   localparam logic [9:0] A_WR   = BASE_ADDR + 10'(OFS_WRITE);
   localparam logic [9:0] A_STAT = BASE_ADDR + 10'(OFS_STAT);

   // {dack_n, iow_n, ior_n} synchronisers plus one delay stage for edge detect
   logic [2:0] s1_q, s2_q;
   logic [1:0] prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= '1;
         s2_q   <= '1;
         prev_q <= '1;
      end else begin
         s1_q   <= {dack_n, iow_n, ior_n};
         s2_q   <= s1_q;
         prev_q <= s2_q[1:0];
      end
   end

   logic ior_fall, ior_rise, iow_rise, dma_cyc, io_sel;
   logic hit_rst, hit_rd, hit_wr, hit_stat;
   logic wr_rst, wr_cmd, rd_evt, dma_xfer, soft_rst;

   assign ior_fall = prev_q[0] & ~s2_q[0];
   assign ior_rise = ~prev_q[0] & s2_q[0];
   assign iow_rise = ~prev_q[1] & s2_q[1];
   assign dma_cyc  = ~s2_q[2];
   assign io_sel   = ~aen & ~dma_cyc;
   assign hit_rst  = io_sel && (a == A_RST);
   assign hit_rd   = io_sel && (a == A_RD);
   assign hit_wr   = io_sel && (a == A_WR);
   assign hit_stat = io_sel && (a == A_STAT);
   assign wr_rst   = iow_rise & hit_rst;
   assign wr_cmd   = iow_rise & hit_wr;
   assign rd_evt   = ior_fall & (hit_rd | hit_wr | hit_stat);

   ps_st_e           ps_q, ps_d;
   dma_st_e          dma_q, dma_d;
   logic [7:0]       op_q, op_d, lo_q, lo_d, tc_q, tc_d;
   logic [15:0]      blk_q, blk_d;
   logic             auto_q, auto_d, exit_q, exit_d, spk_q, spk_d, arm_q, arm_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [7:0]       pcm_q, pcm_d, dout_q, dout_d, q0_q, q0_d, q1_q, q1_d;
   logic             stb_q, stb_d, doe_q, doe_d, irq_q, irq_d;
   logic [1:0]       qcnt_q, qcnt_d;
   logic [ICW-1:0]   icnt_q, icnt_d;
   logic             irq_fire, pace_rst, pace_rdy;

   assign dma_xfer = iow_rise & dma_cyc & (dma_q == DMA_REQ);
   assign soft_rst = wr_rst & arm_q & ~d_in[0];

   sb_dma_pacer #(.CLK_PER_US(CLK_PER_US)) u_pacer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (pace_rst | soft_rst),
      .tc_i  (tc_q),
      .rdy_o (pace_rdy)
   );

   always_comb begin
      ps_d = ps_q;  dma_d = dma_q;  op_d = op_q;  lo_d = lo_q;  tc_d = tc_q;
      blk_d = blk_q;  auto_d = auto_q;  exit_d = exit_q;  spk_d = spk_q;
      arm_d = arm_q;  rem_d = rem_q;  pcm_d = pcm_q;  stb_d = 1'b0;
      dout_d = dout_q;  doe_d = doe_q;  q0_d = q0_q;  q1_d = q1_q;  qcnt_d = qcnt_q;
      irq_d = irq_q;  icnt_d = icnt_q;  irq_fire = 1'b0;  pace_rst = 1'b0;

      if (wr_rst) arm_d = d_in[0];

      if (ior_rise) doe_d = 1'b0;
      if (rd_evt) begin
         doe_d = 1'b1;
         if (hit_rd) begin
            dout_d = q0_q;
            if (qcnt_q != 2'd0) begin
               q0_d   = q1_q;
               qcnt_d = qcnt_q - 2'd1;
            end
         end else if (hit_wr) begin
            dout_d = 8'h00;
         end else begin
            dout_d = {(qcnt_q != 2'd0), 7'h7F};
         end
      end

      case (dma_q)
         DMA_WAIT: if (pace_rdy) begin
            dma_d    = DMA_REQ;
            pace_rst = 1'b1;
         end
         DMA_REQ: if (dma_xfer) begin
            pcm_d = d_in;
            stb_d = 1'b1;
            rem_d = rem_q - LEN_W'(1);
            dma_d = DMA_WAIT;
            if (rem_q == LEN_W'(1)) begin
               irq_fire = 1'b1;
               if (auto_q && !exit_q) rem_d = LEN_W'(blk_q) + LEN_W'(1);
               else                   dma_d = DMA_IDLE;
            end
         end
         default: ;
      endcase

      // Start commands are evaluated after the engine so they win the state on a collision
      if (wr_cmd) begin
         case (ps_q)
            PS_CMD: begin
               op_d = d_in;
               case (d_in)
                  OP_DIRECT, OP_SET_TC, OP_DMA_SC, OP_SET_BLK: ps_d = PS_ARG1;
                  OP_DMA_AI: begin
                     rem_d    = LEN_W'(blk_q) + LEN_W'(1);
                     auto_d   = 1'b1;
                     exit_d   = 1'b0;
                     dma_d    = DMA_WAIT;
                     pace_rst = 1'b1;
                  end
                  OP_PAUSE: if (dma_q == DMA_WAIT || dma_q == DMA_REQ) dma_d = DMA_PAUSE;
                  OP_CONT: if (dma_q == DMA_PAUSE) begin
                     dma_d    = DMA_WAIT;
                     pace_rst = 1'b1;
                  end
                  OP_SPK_ON:  spk_d  = 1'b1;
                  OP_SPK_OFF: spk_d  = 1'b0;
                  OP_EXIT_AI: exit_d = 1'b1;
                  OP_VERSION: begin
                     // Queue holds only two entries, so the version pair replaces any older bytes
                     q0_d   = DSP_VER[15:8];
                     q1_d   = DSP_VER[7:0];
                     qcnt_d = 2'd2;
                  end
                  default: ;
               endcase
            end
            PS_ARG1: begin
               ps_d = PS_CMD;
               if (op_q == OP_DIRECT) begin
                  pcm_d = d_in;
                  stb_d = 1'b1;
               end else if (op_q == OP_SET_TC) begin
                  tc_d = d_in;
               end else begin
                  lo_d = d_in;
                  ps_d = PS_ARG2;
               end
            end
            default: begin
               ps_d = PS_CMD;
               if (op_q == OP_DMA_SC) begin
                  rem_d    = LEN_W'({d_in, lo_q}) + LEN_W'(1);
                  auto_d   = 1'b0;
                  exit_d   = 1'b0;
                  dma_d    = DMA_WAIT;
                  pace_rst = 1'b1;
               end else begin
                  blk_d = {d_in, lo_q};
               end
            end
         endcase
      end

      if (irq_fire) begin
         irq_d  = 1'b1;
         icnt_d = (IRQ_PULSE > 0) ? ICW'(IRQ_PULSE - 1) : '0;
      end else if (IRQ_PULSE == 0) begin
         if (rd_evt && hit_stat) irq_d = 1'b0;
      end else if (irq_q) begin
         if (icnt_q == '0) irq_d  = 1'b0;
         else              icnt_d = icnt_q - ICW'(1);
      end

      // Soft reset mirrors rst_n except that the PCM level is kept
      if (soft_rst) begin
         ps_d = PS_CMD;  dma_d = DMA_IDLE;  op_d = '0;  lo_d = '0;  tc_d = TC_RESET;
         blk_d = '0;  auto_d = 1'b0;  exit_d = 1'b0;  spk_d = 1'b0;  arm_d = 1'b0;
         rem_d = '0;  stb_d = 1'b0;  dout_d = '0;  doe_d = 1'b0;
         q0_d = RESET_ACK;  q1_d = '0;  qcnt_d = 2'd1;  irq_d = 1'b0;  icnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_q <= PS_CMD;  dma_q <= DMA_IDLE;  op_q <= '0;  lo_q <= '0;  tc_q <= TC_RESET;
         blk_q <= '0;  auto_q <= 1'b0;  exit_q <= 1'b0;  spk_q <= 1'b0;  arm_q <= 1'b0;
         rem_q <= '0;  pcm_q <= 8'h80;  stb_q <= 1'b0;  dout_q <= '0;  doe_q <= 1'b0;
         q0_q <= '0;  q1_q <= '0;  qcnt_q <= '0;  irq_q <= 1'b0;  icnt_q <= '0;
      end else begin
         ps_q <= ps_d;  dma_q <= dma_d;  op_q <= op_d;  lo_q <= lo_d;  tc_q <= tc_d;
         blk_q <= blk_d;  auto_q <= auto_d;  exit_q <= exit_d;  spk_q <= spk_d;  arm_q <= arm_d;
         rem_q <= rem_d;  pcm_q <= pcm_d;  stb_q <= stb_d;  dout_q <= dout_d;  doe_q <= doe_d;
         q0_q <= q0_d;  q1_q <= q1_d;  qcnt_q <= qcnt_d;  irq_q <= irq_d;  icnt_q <= icnt_d;
      end
   end

   assign d_out      = dout_q;
   assign d_oe       = doe_q;
   assign drq        = (dma_q == DMA_REQ);
   assign irq        = irq_q;
   assign pcm        = pcm_q;
   assign pcm_stb    = stb_q;
   assign speaker_on = spk_q;
   assign busy       = (dma_q != DMA_IDLE);

endmodule

// File: tb/tb_sb_dsp_dma.sv
// Directed bench for sb_dsp_dma: u0 uses pulsed IRQ (9 clk), u1 level IRQ; both share the bus.
// CLK_PER_US=4 keeps pacing short: TC=83h gives P=500 clk.
module tb_sb_dsp_dma;

   logic       clk = 1'b0;
   logic       rst_n, aen, ior_n, iow_n, dack_n;
   logic [9:0] a;
   logic [7:0] d_in;
   logic [7:0] d_out0, pcm0, d_out1, pcm1;
   logic       d_oe0, drq0, irq0, pcm_stb0, spk0, busy0;
   logic       d_oe1, drq1, irq1, pcm_stb1, spk1, busy1;

   int n_cmp = 0, n_err = 0;

   always #10 clk = ~clk;

   sb_dsp_dma #(.CLK_PER_US(4), .IRQ_PULSE(9)) u0 (
      .clk(clk), .rst_n(rst_n), .a(a), .aen(aen), .ior_n(ior_n), .iow_n(iow_n),
      .dack_n(dack_n), .d_in(d_in), .d_out(d_out0), .d_oe(d_oe0), .drq(drq0), .irq(irq0),
      .pcm(pcm0), .pcm_stb(pcm_stb0), .speaker_on(spk0), .busy(busy0));

   sb_dsp_dma #(.CLK_PER_US(4), .IRQ_PULSE(0)) u1 (
      .clk(clk), .rst_n(rst_n), .a(a), .aen(aen), .ior_n(ior_n), .iow_n(iow_n),
      .dack_n(dack_n), .d_in(d_in), .d_out(d_out1), .d_oe(d_oe1), .drq(drq1), .irq(irq1),
      .pcm(pcm1), .pcm_stb(pcm_stb1), .speaker_on(spk1), .busy(busy1));

   // Event monitor for u0: strobes, drq assertions (with minimum spacing), irq pulse widths
   int cyc = 0, stb_n = 0, drq_n = 0, irq_n = 0, irq_w = 0, irq_run = 0;
   int last_drq = -1, min_gap = 1 << 30;
   logic [7:0] last_pcm = 8'h00;
   logic drq_p = 1'b0, irq_p = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (pcm_stb0) begin
         stb_n++;
         last_pcm = pcm0;
      end
      if (drq0 && !drq_p) begin
         drq_n++;
         if (last_drq >= 0 && (cyc - last_drq) < min_gap) min_gap = cyc - last_drq;
         last_drq = cyc;
      end
      if (irq0) irq_run++;
      else if (irq_p) begin
         irq_n++;
         irq_w   = irq_run;
         irq_run = 0;
      end
      drq_p = drq0;
      irq_p = irq0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic io_wr(input logic [9:0] ad, input logic [7:0] dv);
      a = ad; d_in = dv; aen = 1'b0;
      @(negedge clk);
      iow_n = 1'b0;
      repeat (4) @(negedge clk);
      iow_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic io_rd(input logic [9:0] ad, output logic [7:0] dv, output logic oe);
      a = ad; aen = 1'b0;
      @(negedge clk);
      ior_n = 1'b0;
      repeat (5) @(negedge clk);
      dv = d_out0;
      oe = d_oe0;
      ior_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic dma_ack(input logic [7:0] dv);
      aen = 1'b1; dack_n = 1'b0; d_in = dv;
      @(negedge clk);
      iow_n = 1'b0;
      repeat (4) @(negedge clk);
      iow_n = 1'b1;
      repeat (5) @(negedge clk);
      dack_n = 1'b1; aen = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_drq(input string tag);
      int n = 0;
      while (!drq0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, drq0}, 32'd1);
   endtask

   localparam logic [9:0] P6 = 10'h226, PA = 10'h22A, PC = 10'h22C, PE = 10'h22E;

   logic [7:0] rd;
   logic       oe;
   int s0, d0, i0, t0;

   initial begin
      rst_n = 1'b0; a = '0; aen = 1'b1; ior_n = 1'b1; iow_n = 1'b1; dack_n = 1'b1; d_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_outs", {d_out0, d_oe0, drq0, irq0, pcm0, pcm_stb0, spk0, busy0},
          {8'h00, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0});
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Direct PCM, speaker, then a soft reset that must keep pcm
      s0 = stb_n;
      io_wr(PC, 8'h10); io_wr(PC, 8'h55);
      chk("direct_pcm", {24'd0, pcm0}, 32'h55);
      chk("direct_stb", stb_n - s0, 1);
      io_wr(PC, 8'hD1);
      chk("spk_on", {31'd0, spk0}, 1);
      io_wr(P6, 8'h01); io_wr(P6, 8'h00);
      chk("srst_spk", {31'd0, spk0}, 0);
      chk("srst_pcm_held", {24'd0, pcm0}, 32'h55);

      io_rd(PE, rd, oe);
      chk("stat_avail", {24'd0, rd}, 32'hFF);
      chk("rd_oe", {31'd0, oe}, 1);
      chk("rd_oe_drop", {31'd0, d_oe0}, 0);
      io_rd(PA, rd, oe);  chk("rd_aa", {24'd0, rd}, 32'hAA);
      io_rd(PE, rd, oe);  chk("stat_empty", {24'd0, rd}, 32'h7F);
      io_rd(PC, rd, oe);  chk("wr_status", {24'd0, rd}, 32'h00);

      io_wr(PC, 8'hE1);
      io_rd(PA, rd, oe);  chk("ver_major", {24'd0, rd}, 32'h02);
      io_rd(PA, rd, oe);  chk("ver_minor", {24'd0, rd}, 32'h01);

      // Single-cycle DMA of 4 bytes at TC=83h
      io_wr(PC, 8'h40); io_wr(PC, 8'h83);
      s0 = stb_n; d0 = drq_n; i0 = irq_n;
      io_wr(PC, 8'h14); io_wr(PC, 8'h03); io_wr(PC, 8'h00);
      chk("sc_busy", {31'd0, busy0}, 1);
      for (int i = 0; i < 4; i++) begin
         wait_drq("sc_drq");
         dma_ack(8'hA0 + 8'(i));
      end
      repeat (12) @(negedge clk);
      chk("sc_bytes", stb_n - s0, 4);
      chk("sc_last_pcm", {24'd0, last_pcm}, 32'hA3);
      chk("sc_idle", {31'd0, busy0}, 0);
      chk("sc_irq_cnt", irq_n - i0, 1);
      chk("sc_irq_width", irq_w, 9);
      repeat (1000) @(negedge clk);
      chk("sc_no_extra_drq", drq_n - d0, 4);
      chk("drq_spacing", {31'd0, min_gap >= 500}, 1);
      chk("lvl_irq_held", {31'd0, irq1}, 1);
      io_rd(PE, rd, oe);
      chk("lvl_irq_clr", {31'd0, irq1}, 0);

      // Auto-init with 2-byte blocks, then exit mid-block
      io_wr(PC, 8'h48); io_wr(PC, 8'h01); io_wr(PC, 8'h00);
      s0 = stb_n; d0 = drq_n; i0 = irq_n;
      io_wr(PC, 8'h1C);
      for (int i = 0; i < 4; i++) begin
         wait_drq("ai_drq");
         dma_ack(8'hB0 + 8'(i));
      end
      repeat (12) @(negedge clk);
      chk("ai_irq_per_blk", irq_n - i0, 2);
      chk("ai_still_busy", {31'd0, busy0}, 1);
      wait_drq("ai_drq5");
      dma_ack(8'hB4);
      io_wr(PC, 8'hDA);
      wait_drq("ai_drq6");
      dma_ack(8'hB5);
      repeat (12) @(negedge clk);
      chk("ai_exit_irq", irq_n - i0, 3);
      chk("ai_exit_idle", {31'd0, busy0}, 0);
      chk("ai_bytes", stb_n - s0, 6);
      repeat (700) @(negedge clk);
      chk("ai_no_extra_drq", drq_n - d0, 6);

      // Pause while requesting, ignored DMA cycle, then continue
      s0 = stb_n; d0 = drq_n;
      io_wr(PC, 8'h14); io_wr(PC, 8'h02); io_wr(PC, 8'h00);
      wait_drq("pz_drq1");
      dma_ack(8'hC0);
      wait_drq("pz_drq2");
      io_wr(PC, 8'hD0);
      chk("pz_drq_off", {31'd0, drq0}, 0);
      chk("pz_busy", {31'd0, busy0}, 1);
      dma_ack(8'hCF);
      chk("pz_ack_ignored", stb_n - s0, 1);
      repeat (800) @(negedge clk);
      chk("pz_held", drq_n - d0, 2);
      io_wr(PC, 8'hD4);
      t0 = cyc;
      wait_drq("pz_resume");
      chk("pz_resume_gap", {31'd0, (cyc - t0) >= 490 && (cyc - t0) <= 510}, 1);
      dma_ack(8'hC1);
      wait_drq("pz_drq4");
      dma_ack(8'hC2);
      repeat (12) @(negedge clk);
      chk("pz_bytes", stb_n - s0, 3);
      chk("pz_last_pcm", {24'd0, last_pcm}, 32'hC2);
      chk("pz_idle", {31'd0, busy0}, 0);

      // Hard reset in the middle of a transfer
      chk("lvl_irq_pre_rst", {31'd0, irq1}, 1);
      io_wr(PC, 8'h14); io_wr(PC, 8'h05); io_wr(PC, 8'h00);
      wait_drq("rst_drq");
      rst_n = 1'b0;
      #1;
      chk("rst_mid_u0", {d_out0, d_oe0, drq0, irq0, pcm0, pcm_stb0, spk0, busy0},
          {8'h00, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0});
      chk("rst_mid_u1", {drq1, irq1, busy1, pcm1}, {1'b0, 1'b0, 1'b0, 8'h80});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
